// File: rtl/alu_pkg.sv
// Shared ALU definitions: shift opcodes, flag bit positions and the shift FSM states.
package alu_pkg;

   localparam logic [4:0] OP_LSL = 5'b00001;
   localparam logic [4:0] OP_LSR = 5'b00010;
   localparam logic [4:0] OP_ASR = 5'b00011;
   localparam logic [4:0] OP_ROL = 5'b00100;
   localparam logic [4:0] OP_ROR = 5'b00101;

   localparam int FLAG_Z = 3;
   localparam int FLAG_N = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_DONE
   } state_t;

   function automatic logic op_supported(input logic [4:0] op);
      return (op == OP_LSL) || (op == OP_LSR) || (op == OP_ASR) ||
             (op == OP_ROL) || (op == OP_ROR);
   endfunction

endpackage

// File: rtl/seq_shift_unit_step.sv
// One-bit shift/rotate step. sign_changed is only raised for LSL, since V
// is defined only for that operation.
module shift_step
   import alu_pkg::*;
#(
   parameter int W = 16
) (
   input  logic [4:0]   op,
   input  logic [W-1:0] x,
   output logic [W-1:0] x_next,
   output logic         c_out,
   output logic         sign_changed
);

   always_comb begin
      x_next = x;
      c_out  = 1'b0;
      case (op)
         OP_LSL: begin x_next = {x[W-2:0], 1'b0};     c_out = x[W-1]; end
         OP_LSR: begin x_next = {1'b0, x[W-1:1]};     c_out = x[0];   end
         OP_ASR: begin x_next = {x[W-1], x[W-1:1]};   c_out = x[0];   end
         OP_ROL: begin x_next = {x[W-2:0], x[W-1]};   c_out = x[W-1]; end
         OP_ROR: begin x_next = {x[0], x[W-1:1]};     c_out = x[0];   end
         default: ;
      endcase
      sign_changed = (op == OP_LSL) && (x[W-1] != x[W-2]);
   end

endmodule

// File: rtl/seq_shift_unit.sv
// Multi-cycle shift/rotate engine: one bit per clock, result and flags
// presented with a one-cycle done pulse.
module seq_shift_unit
   import alu_pkg::*;
#(
   parameter int W  = 16,
   parameter int SW = $clog2(W)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [4:0]   alu_op,
   input  logic [W-1:0] operandA,
   input  logic [W-1:0] operandB,
   output logic [W-1:0] result,
   output logic [3:0]   flags,
   output logic         busy,
   output logic         done
);

   state_t        state_q, state_d;
   logic [W-1:0]  result_q, result_d;
   logic [4:0]    op_q, op_d;
   logic [SW-1:0] count_q, count_d;
   logic          c_q, c_d, v_q, v_d;
   logic [3:0]    flags_q, flags_d;
   logic          busy_q, busy_d, done_q, done_d;

   logic [W-1:0]  x_next;
   logic          c_out, sign_changed;
   logic [SW-1:0] amount;
   logic          unused_opb;

   assign amount     = operandB[SW-1:0];
   assign unused_opb = ^operandB[W-1:SW];

   // The result register doubles as the working register while shifting.
   shift_step #(.W(W)) u_step (
      .op           (op_q),
      .x            (result_q),
      .x_next       (x_next),
      .c_out        (c_out),
      .sign_changed (sign_changed)
   );

   always_comb begin
      state_d  = state_q;
      result_d = result_q;
      op_d     = op_q;
      count_d  = count_q;
      c_d      = c_q;
      v_d      = v_q;
      flags_d  = flags_q;
      busy_d   = busy_q;
      done_d   = done_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               result_d = operandA;
               op_d     = alu_op;
               count_d  = amount;
               c_d      = 1'b0;
               v_d      = 1'b0;
               busy_d   = 1'b1;
               if ((amount != '0) && op_supported(alu_op)) begin
                  state_d = ST_SHIFT;
               end else begin
                  state_d         = ST_DONE;
                  done_d          = 1'b1;
                  flags_d         = 4'b0000;
                  flags_d[FLAG_Z] = (operandA == '0);
                  flags_d[FLAG_N] = operandA[W-1];
               end
            end
         end
         ST_SHIFT: begin
            result_d = x_next;
            c_d      = c_out;
            v_d      = v_q | sign_changed;
            count_d  = count_q - 1'b1;
            if (count_q == SW'(1)) begin
               state_d         = ST_DONE;
               done_d          = 1'b1;
               flags_d[FLAG_Z] = (x_next == '0);
               flags_d[FLAG_N] = x_next[W-1];
               flags_d[FLAG_C] = c_out;
               flags_d[FLAG_V] = v_q | sign_changed;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            done_d  = 1'b0;
            busy_d  = 1'b0;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         result_q <= '0;
         op_q     <= '0;
         count_q  <= '0;
         c_q      <= 1'b0;
         v_q      <= 1'b0;
         flags_q  <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         op_q     <= op_d;
         count_q  <= count_d;
         c_q      <= c_d;
         v_q      <= v_d;
         flags_q  <= flags_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign result = result_q;
   assign flags  = flags_q;
   assign busy   = busy_q;
   assign done   = done_q;

endmodule

// File: tb/tb_seq_shift_unit.sv
// Directed-vector bench for seq_shift_unit with hand-computed expectations.
module tb_seq_shift_unit;
   import alu_pkg::*;

   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [4:0]   alu_op;
   logic [W-1:0] operandA, operandB;
   logic [W-1:0] result;
   logic [3:0]   flags;
   logic         busy, done;

   int total = 0;
   int bad   = 0;

   seq_shift_unit #(.W(W)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .alu_op   (alu_op),
      .operandA (operandA),
      .operandB (operandB),
      .result   (result),
      .flags    (flags),
      .busy     (busy),
      .done     (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Issue one op and wait for done; lat counts edges after the accepting edge.
   task automatic issue(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat, output int bcnt);
      @(negedge clk);
      alu_op = op; operandA = a; operandB = b; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 0; bcnt = 0;
      while (!done && lat < 100) begin
         if (busy) bcnt++;
         @(posedge clk); #1;
         lat++;
      end
      if (busy) bcnt++;
      if (!done) chk("timeout", 32'(done), 32'd1);
   endtask

   task automatic run(input string tag, input logic [4:0] op, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic [W-1:0] exp_res,
                      input logic [3:0] exp_flags, input int exp_lat);
      int lat, bcnt;
      issue(op, a, b, lat, bcnt);
      chk({tag, ".lat"},    32'(lat),    32'(exp_lat));
      chk({tag, ".result"}, 32'(result), 32'(exp_res));
      chk({tag, ".flags"},  32'(flags),  32'(exp_flags));
      chk({tag, ".busy"},   32'(bcnt),   32'(exp_lat + 1));
      @(posedge clk); #1;
      chk({tag, ".idle"},   {30'd0, busy, done}, 32'd0);
   endtask

   initial begin
      int lat, bcnt;
      rst = 1'b1; start = 1'b0; alu_op = '0; operandA = '0; operandB = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset.out", {result, flags, busy, done}, 32'd0);
      @(negedge clk); rst = 1'b0;

      // flags are {Z,N,C,V}
      run("lsl",     OP_LSL, 16'd16,   16'd4,      16'd256,  4'b0000, 4);
      run("lsr",     OP_LSR, 16'hFFF3, 16'hFFFD,   16'd7,    4'b0010, 13);
      run("asr",     OP_ASR, 16'hFFF3, 16'd2,      16'hFFFC, 4'b0110, 2);
      run("rol",     OP_ROL, 16'h8001, 16'd1,      16'h0003, 4'b0010, 1);
      run("ror",     OP_ROR, 16'h0001, 16'd3,      16'h2000, 4'b0000, 3);
      run("lslovf",  OP_LSL, 16'h4000, 16'd1,      16'h8000, 4'b0101, 1);
      run("lslzero", OP_LSL, 16'h8000, 16'd1,      16'h0000, 4'b1011, 1);
      run("zeroamt", OP_LSL, 16'd9,    16'd0,      16'd9,    4'b0000, 0);
      run("badop",   5'b00000, 16'h8000, 16'd3,    16'h8000, 4'b0100, 0);

      // A second start while shifting must be dropped.
      @(negedge clk);
      alu_op = OP_LSL; operandA = 16'd1; operandB = 16'd8; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      operandA = 16'd5; operandB = 16'd1; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 3;
      while (!done && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("collide.lat",    32'(lat),    32'd8);
      chk("collide.result", 32'(result), 32'd256);
      @(posedge clk); #1;
      chk("collide.idle", {30'd0, busy, done}, 32'd0);

      // Asynchronous reset in the middle of a shift.
      @(negedge clk);
      alu_op = OP_LSL; operandA = 16'hFFFF; operandB = 16'd10; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      chk("midrst.busy_pre", 32'(busy), 32'd1);
      rst = 1'b1;
      #1;
      chk("midrst.out", {result, flags, busy, done}, 32'd0);
      @(negedge clk); rst = 1'b0;
      run("postrst", OP_LSR, 16'd9, 16'd1, 16'd4, 4'b0010, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule
